instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch unit for the FRiscV CPU. Holds the program counter, issues word requests to instruction memory over a req/gnt/rvalid interface, and presents the fetched instruction to decode with valid/ready. It splits out the `op_code`, `func3` and `func7` fields consumed by `main_controller`. It accepts PC redirects (taken branches, JAL/JALR) from execute and discards any in-flight fetch they make stale.

## Interface
Parameters:
- `RESET_ADDR`, default `32'h0000_0000`, first fetch address after reset; must be word-aligned.

Ports:
- `clk_in`  in  1  clock; all logic on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `imem_req_out`  out  1  fetch request.
- `imem_addr_out`  out  32  word-aligned fetch address.
- `imem_gnt_in`  in  1  request accepted this cycle.
- `imem_rvalid_in`  in  1  read data valid; at least 1 cycle after grant.
- `imem_rdata_in`  in  32  instruction word.
- `instr_valid_out`  out  1  instruction available to decode.
- `instr_ready_in`  in  1  decode accepts the instruction.
- `instr_out`  out  32  fetched instruction.
- `pc_out`  out  32  address of `instr_out`.
- `op_code_out`  out  7  `instr_out[6:0]`.
- `func3_out`  out  3  `instr_out[14:12]`.
- `func7_out`  out  7  `instr_out[31:25]`.
- `redirect_valid_in`  in  1  load new PC.
- `redirect_addr_in`  in  32  new PC.
- `fetch_err_out`  out  1  misaligned redirect error. Present only with the macro; tied 0 otherwise.

## Operation
- FSM states:
  - `IDLE`: reset state. Goes to `REQ` unconditionally.
  - `REQ`: `imem_req_out=1`, `imem_addr_out=pc`. On `gnt`, go to `WAIT`.
  - `WAIT`: on `rvalid`, capture `rdata` into `instr_out` and go to `HOLD`.
  - `HOLD`: `instr_valid_out=1`. On `valid&ready`, `pc<=pc+4` (mod 2^32; wraps at `32'hFFFF_FFFC` to 0) and go to `REQ`.
  - `DRAIN`: a squashed response is outstanding. On `rvalid`, drop the data and go to `REQ`.
  - `ERR`: only with the macro.
- Only one request is outstanding at any time.
- Redirect has priority over every other event, in every state:
  - `pc <= redirect_addr_in`. `instr_valid_out` is low from the next cycle.
  - From `REQ` without `gnt`, `IDLE`, or `HOLD`: go to `REQ`.
  - From `REQ` with `gnt` in the same cycle, or from `WAIT` without `rvalid`: go to `DRAIN`.
  - From `WAIT` with `rvalid` in the same cycle: the data is dropped; go to `REQ`.
  - In `HOLD` with `valid&ready` in the same cycle: the instruction counts as consumed, and the PC takes the redirect address, not `pc+4`.
- While `imem_req_out` is high and no redirect occurs, `imem_addr_out` is stable until `gnt`.
- `rvalid` is ignored in `IDLE`, `REQ` and `HOLD`.
- Field outputs are pure slices of the registered `instr_out`.

## Timing
- Reset values:
  - `pc = RESET_ADDR`, state `IDLE`.
  - `imem_req_out = 0`, `imem_addr_out = RESET_ADDR`.
  - `instr_valid_out = 0`, `instr_out = 32'h0000_0013` (NOP); `pc_out = RESET_ADDR`; field outputs follow NOP.
  - `fetch_err_out = 0`.
- Reset mid-operation discards all state. Instruction memory shares `rst_in`, so no stale response follows reset.
- First request is asserted 1 cycle after `rst_in` falls.
- Latency with `gnt` in the request cycle and `rvalid` 1 cycle later: request at cycle N, `instr_valid_out` at N+2.
- Best-case throughput is 1 instruction per 3 cycles: `REQ`, `WAIT`, `HOLD`.
- The redirect PC appears on `imem_addr_out` 1 cycle after the redirect, or 1 cycle after the drained `rvalid`.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_addr_in[1:0] != 0` enters `ERR`.
  - In `ERR`: no requests, `instr_valid_out=0`, `fetch_err_out=1`.
  - `ERR` is left only by reset or an aligned redirect. An outstanding fetch at the time of the error is drained first, with the error still flagged.
- Undefined:
  - `redirect_addr_in[1:0]` is forced to `2'b00`.
  - No `ERR` state; `fetch_err_out` is tied 0.

## Structure
- Add to `friscv_pkg`:
  - `ifu_state_t` enum: `IDLE`, `REQ`, `WAIT`, `HOLD`, `DRAIN`, `ERR`.
  - `INSTR_NOP = 32'h0000_0013`.
  - `INSTR_BYTES = 4`.
- No sub-module; the FSM, PC register and field slices live in one module.

## Test plan
- Reset, memory grants at once with `rvalid` 1 cycle later, `instr_ready_in=1` held → fetches from `0x0, 0x4, 0x8`; one `instr_valid_out` pulse every 3 cycles; `op_code_out` matches `rdata[6:0]`.
- `instr_ready_in=0` for 5 cycles in `HOLD` → `instr_out` and `pc_out` stable, no new request; PC advances exactly once after `ready`.
- Redirect to `0x100` in `WAIT` → the next `rvalid` data never appears on `instr_out`; next `imem_addr_out=0x100`.
- Redirect to `0x200` on the same cycle as `valid&ready` → next fetch is `0x200`, not `pc+4`.
- PC at `0xFFFF_FFFC` accepted → next fetch address is `0x0`.
- With the macro: redirect to `0x102` → `fetch_err_out=1`, no requests; a later redirect to `0x104` clears the error and fetches `0x104`. Without the macro, the same stimulus fetches `0x100`.

Source files
------------

// File: rtl/friscv_pkg.sv
// rtl/friscv_pkg.sv - FRiscV shared types and constants
package friscv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4,
        ERR   = 3'd5
    } ifu_state_t;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - FRiscV instruction fetch unit (option: IFU_MISALIGN_CHECK_EN)
module instr_fetch_unit
    import friscv_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [6:0]  op_code_out,
    output logic [2:0]  func3_out,
    output logic [6:0]  func7_out,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_addr_in,
    output logic        fetch_err_out
);

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        outstanding;
    ifu_state_t  drain_exit;

`ifdef IFU_MISALIGN_CHECK_EN
    logic        err_q, err_d;
    logic        misaligned;
    logic [31:0] redir_addr;

    assign misaligned    = redirect_addr_in[1:0] != 2'b00;
    assign redir_addr    = redirect_addr_in;
    assign drain_exit    = err_q ? ERR : REQ;
    assign fetch_err_out = err_q;
`else
    logic [31:0] redir_addr;

    assign redir_addr    = redirect_addr_in & 32'hFFFF_FFFC;
    assign drain_exit    = REQ;
    assign fetch_err_out = 1'b0;
`endif

    // A response is still owed by memory after this cycle
    assign outstanding = (state_q == REQ && imem_gnt_in)
                      || ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid_in);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
        err_d      = err_q;
`endif
        if (redirect_valid_in) begin
            pc_d    = redir_addr;
            state_d = outstanding ? DRAIN : REQ;
`ifdef IFU_MISALIGN_CHECK_EN
            err_d = misaligned;
            if (misaligned && !outstanding) begin
                state_d = ERR;
            end
`endif
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_gnt_in) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_in) begin
                        instr_d    = imem_rdata_in;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready_in) begin
                        pc_d    = pc_q + INSTR_BYTES;
                        state_d = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid_in) begin
                        state_d = drain_exit;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            pc_q       <= RESET_ADDR;
            instr_q    <= INSTR_NOP;
            instr_pc_q <= RESET_ADDR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign imem_req_out    = state_q == REQ;
    assign imem_addr_out   = pc_q;
    assign instr_valid_out = state_q == HOLD;
    assign instr_out       = instr_q;
    assign pc_out          = instr_pc_q;
    assign op_code_out     = instr_q[6:0];
    assign func3_out       = instr_q[14:12];
    assign func7_out       = instr_q[31:25];

endmodule
